// File: rtl/data_router_n.sv
// Frame router: a {symbol,prb} config fixes how many beats each channel takes,
// then input beats fill the channels in ascending order through per-channel FWFT FIFOs.
module data_router_n #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_CH     = 4,
  parameter int CNT_WIDTH  = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_CH*2*CNT_WIDTH-1:0]   s_axi_config_data,
  input  logic                            s_axi_config_valid,
  output logic                            s_axi_config_ready,
  input  logic [DATA_WIDTH-1:0]           s_axi_data,
  input  logic                            s_axi_valid,
  output logic                            s_axi_ready,
  output logic [NUM_CH*DATA_WIDTH-1:0]    out_axi_data,
  output logic [NUM_CH-1:0]               out_axi_valid,
  input  logic [NUM_CH-1:0]               out_axi_ready,
  output logic                            frame_done,
  output logic [$clog2(NUM_CH)-1:0]       active_ch
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int LEN_W = 2 * CNT_WIDTH;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    IDLE,
    ROUTE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              started;
  logic [LEN_W-1:0]  cfg_len   [NUM_CH];
  logic [LEN_W-1:0]  remaining [NUM_CH];
  logic [NUM_CH-1:0] fifo_full;
  logic              cfg_xfer;
  logic              data_xfer;
  logic              last_beat;
  logic              first_found;
  logic              next_found;
  logic [CH_W-1:0]   first_ch;
  logic [CH_W-1:0]   next_ch;
  logic [CH_W-1:0]   active_ch_nxt;
  logic              frame_done_nxt;

  // Config is accepted only once the first post-reset edge has been seen.
  assign s_axi_config_ready = started && (state == IDLE);
  assign s_axi_ready        = (state == ROUTE) && !fifo_full[active_ch];
  assign cfg_xfer           = s_axi_config_valid && s_axi_config_ready;
  assign data_xfer          = s_axi_valid && s_axi_ready;
  assign last_beat          = data_xfer && (remaining[active_ch] == LEN_W'(1));

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      cfg_len[k] = LEN_W'(s_axi_config_data[(NUM_CH-1-k)*LEN_W + CNT_WIDTH +: CNT_WIDTH]) *
                   LEN_W'(s_axi_config_data[(NUM_CH-1-k)*LEN_W +: CNT_WIDTH]);
    end
  end

  // Descending scan so the lowest qualifying channel wins.
  always_comb begin
    first_found = 1'b0;
    first_ch    = '0;
    next_found  = 1'b0;
    next_ch     = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (cfg_len[k] != '0) begin
        first_found = 1'b1;
        first_ch    = CH_W'(k);
      end
      if ((CH_W'(k) > active_ch) && (remaining[k] != '0)) begin
        next_found = 1'b1;
        next_ch    = CH_W'(k);
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    active_ch_nxt  = active_ch;
    frame_done_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_xfer) begin
          if (first_found) begin
            state_nxt     = ROUTE;
            active_ch_nxt = first_ch;
          end else begin
            frame_done_nxt = 1'b1;
          end
        end
      end
      ROUTE: begin
        if (last_beat) begin
          if (next_found) begin
            active_ch_nxt = next_ch;
          end else begin
            state_nxt      = IDLE;
            active_ch_nxt  = '0;
            frame_done_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      active_ch  <= '0;
      frame_done <= 1'b0;
      started    <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        remaining[k] <= '0;
      end
    end else begin
      state      <= state_nxt;
      active_ch  <= active_ch_nxt;
      frame_done <= frame_done_nxt;
      started    <= 1'b1;
      if (cfg_xfer) begin
        for (int k = 0; k < NUM_CH; k++) begin
          remaining[k] <= cfg_len[k];
        end
      end else if (data_xfer) begin
        remaining[active_ch] <= remaining[active_ch] - LEN_W'(1);
      end
    end
  end

  // Per-channel FWFT FIFO; a full FIFO refuses writes even when popped that cycle.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_fifo
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  push;
    logic                  pop;

    assign fifo_full[k]     = (count == CNT_W'(FIFO_DEPTH));
    assign push             = data_xfer && (active_ch == CH_W'(k));
    assign pop              = out_axi_valid[k] && out_axi_ready[k];
    assign out_axi_valid[k] = (count != '0);
    assign out_axi_data[k*DATA_WIDTH +: DATA_WIDTH] = out_axi_valid[k] ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
      if (push) begin
        mem[wr_ptr] <= s_axi_data;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_data_router_n.sv
// Self-checking bench for data_router_n: directed frame scenarios plus a
// randomized run checked against a queue-based model of the routing rules.
module tb_data_router_n;

  localparam int DW     = 64;
  localparam int NUM_CH = 4;
  localparam int CW     = 5;
  localparam int DEPTH  = 4;
  localparam int CFG_W  = NUM_CH * 2 * CW;
  localparam int CH_W   = $clog2(NUM_CH);

  logic                 clk = 1'b0;
  logic                 reset;
  logic [CFG_W-1:0]     s_axi_config_data;
  logic                 s_axi_config_valid;
  logic                 s_axi_config_ready;
  logic [DW-1:0]        s_axi_data;
  logic                 s_axi_valid;
  logic                 s_axi_ready;
  logic [NUM_CH*DW-1:0] out_axi_data;
  logic [NUM_CH-1:0]    out_axi_valid;
  logic [NUM_CH-1:0]    out_axi_ready;
  logic                 frame_done;
  logic [CH_W-1:0]      active_ch;

  int checks = 0;
  int errors = 0;

  data_router_n #(
    .DATA_WIDTH (DW),
    .NUM_CH     (NUM_CH),
    .CNT_WIDTH  (CW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .s_axi_config_data  (s_axi_config_data),
    .s_axi_config_valid (s_axi_config_valid),
    .s_axi_config_ready (s_axi_config_ready),
    .s_axi_data         (s_axi_data),
    .s_axi_valid        (s_axi_valid),
    .s_axi_ready        (s_axi_ready),
    .out_axi_data       (out_axi_data),
    .out_axi_valid      (out_axi_valid),
    .out_axi_ready      (out_axi_ready),
    .frame_done         (frame_done),
    .active_ch          (active_ch)
  );

  always #5 clk = ~clk;

  function automatic logic [CFG_W-1:0] cfg_field(input int ch, input int sym, input int prb);
    logic [CFG_W-1:0] v;
    v = '0;
    v[(NUM_CH-1-ch)*2*CW +: 2*CW] = {CW'(sym), CW'(prb)};
    return v;
  endfunction

  function automatic int first_nonzero(input int r[NUM_CH]);
    for (int k = 0; k < NUM_CH; k++) if (r[k] > 0) return k;
    return 0;
  endfunction

  function automatic bit all_zero(input int r[NUM_CH]);
    for (int k = 0; k < NUM_CH; k++) if (r[k] != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Returns at the falling edge following the config transfer, valid dropped.
  task automatic send_config(input logic [CFG_W-1:0] cfg);
    int n;
    @(negedge clk);
    s_axi_config_data  = cfg;
    s_axi_config_valid = 1'b1;
    n = 0;
    #1;
    while (!s_axi_config_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (s_axi_config_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL config_handshake: ready=%b after %0d cycles, expected 1", s_axi_config_ready, n);
    end
    @(negedge clk);
    s_axi_config_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    s_axi_config_data = '0;
    s_axi_config_valid = 1'b0;
    s_axi_data = '0;
    s_axi_valid = 1'b0;
    out_axi_ready = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (s_axi_config_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_cfg_ready: got %b expected 0", s_axi_config_ready); end
    checks++; if (s_axi_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_s_ready: got %b expected 0", s_axi_ready); end
    checks++; if (out_axi_valid !== '0) begin errors++; $display("[TB] FAIL rst_out_valid: got %b expected 0", out_axi_valid); end
    checks++; if (out_axi_data !== '0) begin errors++; $display("[TB] FAIL rst_out_data: got %h expected 0", out_axi_data); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("[TB] FAIL rst_frame_done: got %b expected 0", frame_done); end
    checks++; if (active_ch !== '0) begin errors++; $display("[TB] FAIL rst_active_ch: got %0d expected 0", active_ch); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (s_axi_config_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_cfg_ready_pre_edge: got %b expected 0", s_axi_config_ready); end
    @(negedge clk);
    #1;
    checks++; if (s_axi_config_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_cfg_ready_post_edge: got %b expected 1", s_axi_config_ready); end
    checks++; if (s_axi_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_idle_s_ready: got %b expected 0", s_axi_ready); end
  endtask

  task automatic test_basic();
    int exp_ch [9];
    logic [DW-1:0] beat;
    exp_ch = '{0, 0, 0, 0, 0, 0, 2, 3, 3};
    out_axi_ready = '1;
    send_config(cfg_field(0, 2, 3) | cfg_field(1, 0, 5) | cfg_field(2, 1, 1) | cfg_field(3, 1, 2));
    s_axi_valid = 1'b1;
    for (int b = 1; b <= 9; b++) begin
      beat = 64'hA000_0000_0000_0000 + DW'(b);
      s_axi_data = beat;
      #1;
      checks++; if (s_axi_ready !== 1'b1) begin errors++; $display("[TB] FAIL basic_s_ready beat %0d: got %b expected 1", b, s_axi_ready); end
      checks++; if (active_ch !== CH_W'(exp_ch[b-1])) begin errors++; $display("[TB] FAIL basic_active_ch beat %0d: got %0d expected %0d", b, active_ch, exp_ch[b-1]); end
      @(negedge clk);
      checks++; if (out_axi_valid !== NUM_CH'(1 << exp_ch[b-1])) begin errors++; $display("[TB] FAIL basic_out_valid beat %0d: got %b expected %b", b, out_axi_valid, NUM_CH'(1 << exp_ch[b-1])); end
      checks++; if (out_axi_data[exp_ch[b-1]*DW +: DW] !== beat) begin errors++; $display("[TB] FAIL basic_out_data beat %0d: got %h expected %h", b, out_axi_data[exp_ch[b-1]*DW +: DW], beat); end
      checks++; if (frame_done !== (b == 9)) begin errors++; $display("[TB] FAIL basic_frame_done beat %0d: got %b expected %b", b, frame_done, (b == 9)); end
    end
    s_axi_valid = 1'b0;
    #1;
    checks++; if (s_axi_config_ready !== 1'b1) begin errors++; $display("[TB] FAIL basic_cfg_ready_end: got %b expected 1", s_axi_config_ready); end
    checks++; if (active_ch !== '0) begin errors++; $display("[TB] FAIL basic_active_ch_idle: got %0d expected 0", active_ch); end
    @(negedge clk);
    #1;
    checks++; if (frame_done !== 1'b0) begin errors++; $display("[TB] FAIL basic_frame_done_width: got %b expected 0", frame_done); end
    checks++; if (out_axi_valid !== '0) begin errors++; $display("[TB] FAIL basic_drained: got %b expected 0", out_axi_valid); end
  endtask

  task automatic test_zero_config();
    out_axi_ready = '1;
    send_config('0);
    #1;
    checks++; if (frame_done !== 1'b1) begin errors++; $display("[TB] FAIL zero_frame_done: got %b expected 1", frame_done); end
    checks++; if (s_axi_config_ready !== 1'b1) begin errors++; $display("[TB] FAIL zero_cfg_ready: got %b expected 1", s_axi_config_ready); end
    checks++; if (s_axi_ready !== 1'b0) begin errors++; $display("[TB] FAIL zero_s_ready: got %b expected 0", s_axi_ready); end
    @(negedge clk);
    #1;
    checks++; if (frame_done !== 1'b0) begin errors++; $display("[TB] FAIL zero_frame_done_width: got %b expected 0", frame_done); end
    checks++; if (s_axi_ready !== 1'b0) begin errors++; $display("[TB] FAIL zero_s_ready_after: got %b expected 0", s_axi_ready); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] base;
    logic [DW-1:0] got [$];
    int acc;
    int fd;
    base = 64'hB000_0000_0000_0000;
    acc = 0;
    fd = 0;
    out_axi_ready = '0;
    send_config(cfg_field(0, 1, 8));
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (cyc == 12) begin
        checks++; if (acc != 4) begin errors++; $display("[TB] FAIL bp_accepted_while_blocked: got %0d expected 4", acc); end
        checks++; if (s_axi_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_s_ready_full: got %b expected 0", s_axi_ready); end
        checks++; if (out_axi_data[DW-1:0] !== base + DW'(1)) begin errors++; $display("[TB] FAIL bp_head: got %h expected %h", out_axi_data[DW-1:0], base + DW'(1)); end
        out_axi_ready = NUM_CH'(1);
      end
      if (acc < 8) begin
        s_axi_valid = 1'b1;
        s_axi_data  = base + DW'(acc + 1);
      end else begin
        s_axi_valid = 1'b0;
      end
      #1;
      if (frame_done) fd++;
      if (out_axi_valid[0] && out_axi_ready[0]) got.push_back(out_axi_data[DW-1:0]);
      if (s_axi_valid && s_axi_ready) acc++;
    end
    s_axi_valid = 1'b0;
    out_axi_ready = '1;
    checks++; if (acc != 8) begin errors++; $display("[TB] FAIL bp_total_accepted: got %0d expected 8", acc); end
    checks++; if (got.size() != 8) begin errors++; $display("[TB] FAIL bp_total_out: got %0d expected 8", got.size()); end
    for (int i = 0; i < got.size() && i < 8; i++) begin
      checks++; if (got[i] !== base + DW'(i + 1)) begin errors++; $display("[TB] FAIL bp_order idx %0d: got %h expected %h", i, got[i], base + DW'(i + 1)); end
    end
    checks++; if (fd != 1) begin errors++; $display("[TB] FAIL bp_frame_done_count: got %0d expected 1", fd); end
  endtask

  task automatic test_long_frame();
    logic [DW-1:0] base;
    int acc;
    int pops;
    int fd;
    int fd_acc;
    int stray;
    base = 64'h5A00_0000_0000_0000;
    acc = 0; pops = 0; fd = 0; fd_acc = -1; stray = 0;
    out_axi_ready = '1;
    send_config(cfg_field(1, 31, 31));
    for (int cyc = 0; cyc < 1000; cyc++) begin
      if (acc < 961) begin
        s_axi_valid = 1'b1;
        s_axi_data  = base + DW'(acc);
      end else begin
        s_axi_valid = 1'b0;
      end
      #1;
      if (frame_done) begin
        fd++;
        fd_acc = acc;
      end
      if ((out_axi_valid & 4'b1101) != '0) stray++;
      if (out_axi_valid[1] && out_axi_ready[1]) begin
        checks++;
        if (out_axi_data[DW +: DW] !== base + DW'(pops)) begin
          errors++;
          $display("[TB] FAIL long_order idx %0d: got %h expected %h", pops, out_axi_data[DW +: DW], base + DW'(pops));
        end
        pops++;
      end
      if (s_axi_valid && s_axi_ready) acc++;
      @(negedge clk);
    end
    s_axi_valid = 1'b0;
    checks++; if (acc != 961) begin errors++; $display("[TB] FAIL long_accepted: got %0d expected 961", acc); end
    checks++; if (pops != 961) begin errors++; $display("[TB] FAIL long_delivered: got %0d expected 961", pops); end
    checks++; if (fd != 1) begin errors++; $display("[TB] FAIL long_frame_done_count: got %0d expected 1", fd); end
    checks++; if (fd_acc != 961) begin errors++; $display("[TB] FAIL long_frame_done_at: got %0d expected 961", fd_acc); end
    checks++; if (stray != 0) begin errors++; $display("[TB] FAIL long_stray_channels: got %0d expected 0", stray); end
  endtask

  task automatic test_reset_midframe();
    int acc;
    int exp_ch [3];
    logic [DW-1:0] beat;
    exp_ch = '{0, 2, 2};
    acc = 0;
    out_axi_ready = '0;
    send_config(cfg_field(0, 2, 3));
    for (int cyc = 0; cyc < 20 && acc < 3; cyc++) begin
      s_axi_valid = 1'b1;
      s_axi_data  = 64'hD000_0000_0000_0000 + DW'(acc);
      #1;
      if (s_axi_ready) acc++;
      @(negedge clk);
    end
    s_axi_valid = 1'b0;
    checks++; if (acc != 3) begin errors++; $display("[TB] FAIL mid_pre_accept: got %0d expected 3", acc); end
    #2 reset = 1'b1;
    #1;
    checks++; if (out_axi_valid !== '0) begin errors++; $display("[TB] FAIL mid_out_valid: got %b expected 0", out_axi_valid); end
    checks++; if (out_axi_data !== '0) begin errors++; $display("[TB] FAIL mid_out_data: got %h expected 0", out_axi_data); end
    checks++; if (s_axi_ready !== 1'b0) begin errors++; $display("[TB] FAIL mid_s_ready: got %b expected 0", s_axi_ready); end
    checks++; if (s_axi_config_ready !== 1'b0) begin errors++; $display("[TB] FAIL mid_cfg_ready: got %b expected 0", s_axi_config_ready); end
    checks++; if (active_ch !== '0) begin errors++; $display("[TB] FAIL mid_active_ch: got %0d expected 0", active_ch); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (s_axi_config_ready !== 1'b0) begin errors++; $display("[TB] FAIL mid_cfg_ready_pre_edge: got %b expected 0", s_axi_config_ready); end
    @(negedge clk);
    #1;
    checks++; if (s_axi_config_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_cfg_ready_post: got %b expected 1", s_axi_config_ready); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("[TB] FAIL mid_no_frame_done: got %b expected 0", frame_done); end
    out_axi_ready = '1;
    send_config(cfg_field(0, 1, 1) | cfg_field(2, 1, 2));
    s_axi_valid = 1'b1;
    for (int b = 1; b <= 3; b++) begin
      beat = 64'hE000_0000_0000_0000 + DW'(b);
      s_axi_data = beat;
      @(negedge clk);
      checks++; if (out_axi_valid !== NUM_CH'(1 << exp_ch[b-1])) begin errors++; $display("[TB] FAIL mid_next_valid beat %0d: got %b expected %b", b, out_axi_valid, NUM_CH'(1 << exp_ch[b-1])); end
      checks++; if (out_axi_data[exp_ch[b-1]*DW +: DW] !== beat) begin errors++; $display("[TB] FAIL mid_next_data beat %0d: got %h expected %h", b, out_axi_data[exp_ch[b-1]*DW +: DW], beat); end
      checks++; if (frame_done !== (b == 3)) begin errors++; $display("[TB] FAIL mid_next_frame_done beat %0d: got %b expected %b", b, frame_done, (b == 3)); end
    end
    s_axi_valid = 1'b0;
    @(negedge clk);
  endtask

  // Model: lengths per channel, fill lowest nonzero channel first, one queue per FIFO.
  task automatic test_random();
    logic [DW-1:0]    mq [NUM_CH][$];
    int               mrem [NUM_CH];
    int               pend_len [NUM_CH];
    logic [CFG_W-1:0] cfg;
    logic [DW-1:0]    exp_d;
    bit               in_frame, done_now, done_next, d_taken, c_taken, zero_all, exp_v, exp_rdy;
    int               cfg_left, cyc, cur, sym, prb, pending;
    for (int k = 0; k < NUM_CH; k++) begin
      mrem[k] = 0;
      pend_len[k] = 0;
      mq[k].delete();
    end
    in_frame = 0; done_now = 0; d_taken = 0; c_taken = 0;
    cfg_left = 50; cyc = 0; pending = 0;
    s_axi_valid = 1'b0;
    s_axi_config_valid = 1'b0;
    while ((cfg_left > 0 || in_frame || done_now || pending > 0) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (d_taken) s_axi_valid = 1'b0;
      if (c_taken) s_axi_config_valid = 1'b0;
      if (!s_axi_valid && $urandom_range(0, 3) != 0) begin
        s_axi_valid = 1'b1;
        s_axi_data  = {$urandom(), $urandom()};
      end
      if (!s_axi_config_valid && cfg_left > 0 && $urandom_range(0, 1) == 1) begin
        cfg = '0;
        zero_all = ($urandom_range(0, 7) == 0);
        for (int k = 0; k < NUM_CH; k++) begin
          sym = zero_all ? 0 : int'($urandom_range(0, 3));
          prb = zero_all ? 0 : int'($urandom_range(0, 3));
          pend_len[k] = sym * prb;
          cfg = cfg | cfg_field(k, sym, prb);
        end
        s_axi_config_valid = 1'b1;
        s_axi_config_data  = cfg;
      end
      out_axi_ready = NUM_CH'($urandom());
      #1;
      cur = first_nonzero(mrem);
      exp_rdy = in_frame && (mq[cur].size() < DEPTH);
      checks++; if (s_axi_config_ready !== !in_frame) begin errors++; $display("[TB] FAIL rnd_cfg_ready cyc %0d: got %b expected %b", cyc, s_axi_config_ready, !in_frame); end
      checks++; if (s_axi_ready !== exp_rdy) begin errors++; $display("[TB] FAIL rnd_s_ready cyc %0d: got %b expected %b", cyc, s_axi_ready, exp_rdy); end
      checks++; if (active_ch !== CH_W'(in_frame ? cur : 0)) begin errors++; $display("[TB] FAIL rnd_active_ch cyc %0d: got %0d expected %0d", cyc, active_ch, in_frame ? cur : 0); end
      checks++; if (frame_done !== done_now) begin errors++; $display("[TB] FAIL rnd_frame_done cyc %0d: got %b expected %b", cyc, frame_done, done_now); end
      for (int k = 0; k < NUM_CH; k++) begin
        exp_v = (mq[k].size() > 0);
        exp_d = exp_v ? mq[k][0] : '0;
        checks++; if (out_axi_valid[k] !== exp_v) begin errors++; $display("[TB] FAIL rnd_out_valid ch %0d cyc %0d: got %b expected %b", k, cyc, out_axi_valid[k], exp_v); end
        checks++; if (out_axi_data[k*DW +: DW] !== exp_d) begin errors++; $display("[TB] FAIL rnd_out_data ch %0d cyc %0d: got %h expected %h", k, cyc, out_axi_data[k*DW +: DW], exp_d); end
      end
      done_next = 0;
      for (int k = 0; k < NUM_CH; k++) begin
        if (out_axi_valid[k] && out_axi_ready[k] && mq[k].size() > 0) void'(mq[k].pop_front());
      end
      d_taken = s_axi_valid && s_axi_ready;
      c_taken = s_axi_config_valid && s_axi_config_ready;
      if (d_taken && in_frame) begin
        mq[cur].push_back(s_axi_data);
        mrem[cur]--;
        if (all_zero(mrem)) begin
          in_frame  = 0;
          done_next = 1;
        end
      end
      if (c_taken) begin
        cfg_left--;
        mrem = pend_len;
        if (all_zero(mrem)) done_next = 1;
        else in_frame = 1;
      end
      done_now = done_next;
      pending = 0;
      for (int k = 0; k < NUM_CH; k++) pending += mq[k].size();
    end
    s_axi_valid = 1'b0;
    s_axi_config_valid = 1'b0;
    out_axi_ready = '1;
    checks++; if (cyc >= 20000) begin errors++; $display("[TB] FAIL rnd_timeout: got %0d cycles, expected fewer than 20000 (configs left %0d)", cyc, cfg_left); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_config();
    test_backpressure();
    test_long_frame();
    test_reset_midframe();
    test_random();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/data_router_n.md
DATA_ROUTER_N -- requirements
Module: data_router_n

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, meaning width of every data beat.
REQ-002 SHALL have parameter NUM_CH, default 4, range 2..16, meaning number of output channels.
REQ-003 SHALL have parameter CNT_WIDTH, default 5, meaning width of each symbol and prb field.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, power of two >=2, meaning per-channel output FIFO entries.
REQ-005 SHALL have port clk  input  1  the single clock; all logic on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port s_axi_config_data  input  NUM_CH*2*CNT_WIDTH  packed {symbol,prb} pairs, channel 0 in the MSBs, symbol above prb within each pair.
REQ-008 SHALL have ports s_axi_config_valid input 1 and s_axi_config_ready output 1, the config handshake.
REQ-009 SHALL have port s_axi_data  input  DATA_WIDTH  input beat.
REQ-010 SHALL have ports s_axi_valid input 1 and s_axi_ready output 1, the input data handshake.
REQ-011 SHALL have port out_axi_data  output  NUM_CH*DATA_WIDTH  channel k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-012 SHALL have ports out_axi_valid output NUM_CH and out_axi_ready input NUM_CH, one bit per channel.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse when a config frame completes.
REQ-014 SHALL have port active_ch  output  $clog2(NUM_CH)  channel currently being filled; 0 in IDLE.

Function
REQ-015 A transfer SHALL occur on a rising clk edge where valid and ready are both 1; valid SHALL be held by the source until the transfer.
REQ-016 The controller SHALL have states IDLE and ROUTE; s_axi_config_ready=1 only in IDLE; s_axi_ready=0 in IDLE.
REQ-017 On config transfer, length[k]=symbol[k]*prb[k] (2*CNT_WIDTH bits, no overflow) SHALL be latched for every channel.
REQ-018 On config transfer, the FSM SHALL go to ROUTE with active_ch = lowest k having length[k]!=0; if all lengths are 0, it SHALL stay IDLE and pulse frame_done the next cycle.
REQ-019 In ROUTE, s_axi_ready SHALL equal !full[active_ch]; each accepted beat SHALL be written to FIFO[active_ch] and decrement that channel's remaining count.
REQ-020 When a channel's last beat is accepted, active_ch SHALL advance to the next higher k with length[k]!=0, skipping zero-length channels, with no bubble cycle.
REQ-021 When the last beat of the last nonzero channel is accepted, the FSM SHALL enter IDLE and frame_done SHALL be 1 for exactly the following cycle; config ready SHALL be 1 from that cycle.
REQ-022 Each FIFO SHALL be first-word-fall-through: a word written at edge N SHALL show out_axi_valid[k]=1 and data after edge N; pop SHALL occur on out_axi_valid[k]&&out_axi_ready[k].
REQ-023 Full SHALL be count==FIFO_DEPTH; a full FIFO SHALL NOT accept a write even if popped the same cycle (no bypass); simultaneous push and pop on a non-full, non-empty FIFO SHALL keep count unchanged.
REQ-024 Per-channel beat order SHALL equal input order; channels SHALL drain independently while routing continues to others.
REQ-025 out_axi_data[k] SHALL be 0 while out_axi_valid[k]=0.

Reset
REQ-026 While reset=1: FSM=IDLE, all FIFOs empty, remaining counts 0, s_axi_ready=0, out_axi_valid=0, out_axi_data=0, frame_done=0, active_ch=0, s_axi_config_ready=0.
REQ-027 The first rising edge after reset deassertion SHALL set s_axi_config_ready=1; reset mid-frame SHALL discard all buffered beats and the latched config without frame_done.

Verification
REQ-028 NUM_CH=4, config (2,3),(0,5),(1,1),(1,2), all out ready=1, 9 input beats -> ch0 gets beats 1-6, ch1 none, ch2 beat 7, ch3 beats 8-9, frame_done pulses once the cycle after beat 9.
REQ-029 Config all zeros -> s_axi_ready stays 0, frame_done pulses the cycle after config transfer, config ready 1 again that cycle.
REQ-030 Config (1,8) on ch0 only, out_axi_ready[0]=0, FIFO_DEPTH=4 -> s_axi_ready drops after 4 beats; raise out_axi_ready[0] -> remaining 4 beats accepted, all 8 emerge in order.
REQ-031 Config (31,31) on ch1 -> 961 beats routed to ch1, counter no wrap, frame_done after beat 961.
REQ-032 Reset asserted after 3 of 6 beats -> all out_axi_valid=0 immediately, config ready 1 after deassertion, next frame routes correctly.
REQ-033 Random valid/ready throttling on all ports over 50 random configs -> scoreboard per channel matches input order and counts exactly.
